icache_fetch: RTL and testbench



---
 rtl/icache_pkg.sv | 22 ++
 rtl/icache_refill_fsm.sv | 115 +++++++++++
 rtl/icache_fetch.sv | 127 ++++++++++++
 tb/tb_icache_fetch.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared types and geometry helpers for the direct-mapped instruction cache.
package icache_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REFILL = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   function automatic int off_w(input int words_per_line);
      return $clog2(words_per_line);
   endfunction

   function automatic int idx_w(input int lines);
      return $clog2(lines);
   endfunction

   function automatic int tag_w(input int addr_w, input int lines, input int words_per_line);
      return addr_w - $clog2(lines) - $clog2(words_per_line) - 2;
   endfunction

endpackage

// File: rtl/icache_refill_fsm.sv
// Miss handling for icache_fetch: holds the miss address, walks the line word by
// word over the mem_req/mem_ready handshake and signals when the line is complete.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | lookup active; a miss latches tag/index and starts a refill
// ST_REFILL | mem_req high, one word written per mem_ready
// ST_DONE   | one bubble cycle; a flush seen during the refill is applied
module icache_refill_fsm
   import icache_pkg::*;
#(
   parameter  int LINES          = 16,
   parameter  int WORDS_PER_LINE = 4,
   parameter  int ADDR_W         = 32,
   localparam int OFF_W          = off_w(WORDS_PER_LINE),
   localparam int IDX_W          = idx_w(LINES),
   localparam int TAG_W          = tag_w(ADDR_W, LINES, WORDS_PER_LINE)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_miss,
   input  logic              i_flush,
   input  logic [TAG_W-1:0]  i_tag,
   input  logic [IDX_W-1:0]  i_idx,
   input  logic              i_mem_ready,
   output state_t            o_state,
   output logic              o_mem_req,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic              o_wr_en,
   output logic [IDX_W-1:0]  o_wr_idx,
   output logic [OFF_W-1:0]  o_wr_off,
   output logic [TAG_W-1:0]  o_wr_tag,
   output logic              o_fill_done,
   output logic              o_flush_apply
);

   localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS_PER_LINE - 1);

   state_t             r_state;
   state_t             w_next_state;
   logic [OFF_W-1:0]   r_cnt;
   logic [TAG_W-1:0]   r_tag;
   logic [IDX_W-1:0]   r_idx;
   logic               r_flush_pend;
   logic               w_last;

   assign w_last = (r_cnt == LAST_WORD);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state  = r_state;
      o_mem_req     = 1'b0;
      o_mem_addr    = '0;
      o_wr_en       = 1'b0;
      o_fill_done   = 1'b0;
      o_flush_apply = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_miss) w_next_state = ST_REFILL;
         end
         ST_REFILL: begin
            o_mem_req   = 1'b1;
            o_mem_addr  = {r_tag, r_idx, r_cnt, 2'b00};
            o_wr_en     = i_mem_ready;
            o_fill_done = i_mem_ready && w_last;
            if (i_mem_ready && w_last) w_next_state = ST_DONE;
         end
         ST_DONE: begin
            o_flush_apply = r_flush_pend || i_flush;
            w_next_state  = ST_IDLE;
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   // Counter returns to 0 only on the final accepted word, i.e. when leaving REFILL.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt        <= '0;
         r_tag        <= '0;
         r_idx        <= '0;
         r_flush_pend <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_miss) begin
                  r_tag        <= i_tag;
                  r_idx        <= i_idx;
                  r_cnt        <= '0;
                  r_flush_pend <= 1'b0;
               end
            end
            ST_REFILL: begin
               if (i_mem_ready) r_cnt <= w_last ? '0 : r_cnt + OFF_W'(1);
               if (i_flush) r_flush_pend <= 1'b1;
            end
            ST_DONE: r_flush_pend <= 1'b0;
            default: r_flush_pend <= 1'b0;
         endcase
      end
   end

   assign o_state  = r_state;
   assign o_wr_idx = r_idx;
   assign o_wr_off = r_cnt;
   assign o_wr_tag = r_tag;

endmodule

// File: rtl/icache_fetch.sv
// Direct-mapped read-only instruction cache for the IF stage; combinational hit path.
// Define ICACHE_STATS_EN to add saturating hit_count / miss_count outputs.
module icache_fetch
   import icache_pkg::*;
#(
   parameter int LINES          = 16,
   parameter int WORDS_PER_LINE = 4,
   parameter int ADDR_W         = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] pc,
   input  logic              flush,
   output logic [31:0]       instruction,
   output logic              hit,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ready,
   input  logic [31:0]       mem_rdata
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0]       hit_count,
   output logic [31:0]       miss_count
`endif
);

   localparam int OFF_W = off_w(WORDS_PER_LINE);
   localparam int IDX_W = idx_w(LINES);
   localparam int TAG_W = tag_w(ADDR_W, LINES, WORDS_PER_LINE);

   logic [LINES-1:0]  r_valid;
   logic [TAG_W-1:0]  r_tags [LINES];
   logic [31:0]       r_data [LINES][WORDS_PER_LINE];

   logic [OFF_W-1:0]  w_off;
   logic [IDX_W-1:0]  w_idx;
   logic [TAG_W-1:0]  w_tag;
   logic              w_lookup;
   logic              w_idle;
   logic              w_miss;
   state_t            w_state;
   logic              w_wr_en;
   logic [IDX_W-1:0]  w_wr_idx;
   logic [OFF_W-1:0]  w_wr_off;
   logic [TAG_W-1:0]  w_wr_tag;
   logic              w_fill_done;
   logic              w_flush_apply;
   logic              w_unused_pc;

   assign w_off       = pc[OFF_W+1:2];
   assign w_idx       = pc[IDX_W+OFF_W+1:OFF_W+2];
   assign w_tag       = pc[ADDR_W-1:IDX_W+OFF_W+2];
   assign w_unused_pc = ^pc[1:0];

   // A flush in IDLE both hides the hit and suppresses a refill that cycle.
   assign w_lookup    = r_valid[w_idx] && (r_tags[w_idx] == w_tag);
   assign w_idle      = (w_state == ST_IDLE);
   assign hit         = w_idle && w_lookup && !flush;
   assign w_miss      = w_idle && !w_lookup && !flush;
   assign instruction = r_data[w_idx][w_off];

   icache_refill_fsm #(
      .LINES          (LINES),
      .WORDS_PER_LINE (WORDS_PER_LINE),
      .ADDR_W         (ADDR_W)
   ) u_refill (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_miss        (w_miss),
      .i_flush       (flush),
      .i_tag         (w_tag),
      .i_idx         (w_idx),
      .i_mem_ready   (mem_ready),
      .o_state       (w_state),
      .o_mem_req     (mem_req),
      .o_mem_addr    (mem_addr),
      .o_wr_en       (w_wr_en),
      .o_wr_idx      (w_wr_idx),
      .o_wr_off      (w_wr_off),
      .o_wr_tag      (w_wr_tag),
      .o_fill_done   (w_fill_done),
      .o_flush_apply (w_flush_apply)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= '0;
      end else if ((w_idle && flush) || w_flush_apply) begin
         r_valid <= '0;
      end else if (w_fill_done) begin
         r_valid[w_wr_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_en) r_data[w_wr_idx][w_wr_off] <= mem_rdata;
      if (w_fill_done) r_tags[w_wr_idx] <= w_wr_tag;
   end

`ifdef ICACHE_STATS_EN
   logic [31:0]       r_hit_count;
   logic [31:0]       r_miss_count;
   logic [ADDR_W-3:0] r_last_pc;
   logic              r_last_vld;

   // Only a new pc counts as a hit, so a stalled fetch is not counted twice.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hit_count  <= '0;
         r_miss_count <= '0;
         r_last_pc    <= '0;
         r_last_vld   <= 1'b0;
      end else begin
         if (hit && (!r_last_vld || (pc[ADDR_W-1:2] != r_last_pc))) begin
            if (r_hit_count != 32'hFFFF_FFFF) r_hit_count <= r_hit_count + 32'd1;
            r_last_pc  <= pc[ADDR_W-1:2];
            r_last_vld <= 1'b1;
         end
         if (w_miss && (r_miss_count != 32'hFFFF_FFFF)) r_miss_count <= r_miss_count + 32'd1;
      end
   end

   assign hit_count  = r_hit_count;
   assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_icache_fetch.sv
// Scoreboard bench for icache_fetch: a stimulus process issues fetches and pushes the
// expected word/refill count, a memory responder serves refills, a monitor checks hits.
module tb_icache_fetch;

   localparam int LINES = 16;
   localparam int WPL   = 4;
   localparam int AW    = 32;

   logic          clk       = 1'b0;
   logic          rst_n     = 1'b0;
   logic [AW-1:0] pc        = 32'h40;
   logic          flush     = 1'b0;
   logic          mem_ready = 1'b0;
   logic [31:0]   mem_rdata = '0;
   logic [31:0]   instruction;
   logic          hit;
   logic          mem_req;
   logic [AW-1:0] mem_addr;
`ifdef ICACHE_STATS_EN
   logic [31:0]   hit_count;
   logic [31:0]   miss_count;
`endif

   icache_fetch #(.LINES(LINES), .WORDS_PER_LINE(WPL), .ADDR_W(AW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pc          (pc),
      .flush       (flush),
      .instruction (instruction),
      .hit         (hit),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_ready   (mem_ready),
      .mem_rdata   (mem_rdata)
`ifdef ICACHE_STATS_EN
      ,
      .hit_count   (hit_count),
      .miss_count  (miss_count)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
      int          refills;
      int          issue_cyc;
      int          refills_base;
   } exp_t;

   exp_t sb[$];

   // Reference model: which lines hold which tag, plus the backing memory contents.
   bit          mv[LINES];
   logic [23:0] mt[LINES];

   int          mem_delay      = 0;
   bit          rand_delay     = 1'b0;
   int          cur_delay      = 0;
   int          wait_cnt       = 0;
   int          words          = 0;
   int          refills_done   = 0;
   int          last_ready_cyc = -100;
   logic [31:0] exp_base       = 32'h40;
   logic        prev_req       = 1'b0;
   logic        prev_ready     = 1'b0;
   logic [31:0] prev_addr      = '0;

   function automatic logic [31:0] memword(input logic [31:0] a);
      if (a[31:4] == 28'h4) return 32'hA0 + 32'(a[3:2]);
      return (a * 32'h9E37_79B1) ^ 32'h00C0_FFEE;
   endfunction

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < LINES; i++) mv[i] = 1'b0;
   endtask

   // Memory responder: serves refill words and checks the request side.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) begin
            words      = 0;
            wait_cnt   = 0;
            mem_ready  = 1'b0;
            prev_req   = 1'b0;
            prev_ready = 1'b0;
            continue;
         end
         if (prev_req && !mem_req) begin
            check32("words_per_refill", 32'(words), 32'(WPL));
            words = 0;
         end
         if (mem_req && prev_req && !prev_ready) check32("addr_stable", mem_addr, prev_addr);
         if (mem_req && !prev_req) begin
            wait_cnt  = 0;
            cur_delay = rand_delay ? int'($urandom_range(0, 3)) : mem_delay;
         end
         mem_ready = 1'b0;
         if (mem_req) begin
            if (wait_cnt >= cur_delay) begin
               check32("refill_addr", mem_addr, exp_base + 32'(words * 4));
               mem_ready = 1'b1;
               mem_rdata = memword(mem_addr);
               words++;
               wait_cnt  = 0;
               cur_delay = rand_delay ? int'($urandom_range(0, 3)) : mem_delay;
               if (words == WPL) begin
                  refills_done++;
                  last_ready_cyc = cyc;
               end
            end else begin
               wait_cnt++;
            end
         end
         prev_req   = mem_req;
         prev_ready = mem_ready;
         prev_addr  = mem_addr;
      end
   end

   // Monitor: pops one expectation per presented hit.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && flush) check32("hit_during_flush", 32'(hit), 32'd0);
         if (rst_n && hit && sb.size() > 0) begin
            e = sb.pop_front();
            check32("instruction", instruction, e.data);
            check32("refill_count", 32'(refills_done - e.refills_base), 32'(e.refills));
            check32("mem_req_on_hit", 32'(mem_req), 32'd0);
            if (e.refills == 0) check32("hit_latency", 32'(cyc), 32'(e.issue_cyc));
            else check32("miss_latency", 32'(cyc), 32'(last_ready_cyc + 2));
         end
      end
   end

   task automatic issue(input logic [31:0] a, input int nref);
      exp_t e;
      @(posedge clk);
      #1;
      exp_base       = {a[31:4], 4'h0};
      pc             = a;
      e.pc           = a;
      e.data         = memword({a[31:2], 2'b00});
      e.refills      = (nref >= 0) ? nref : ((mv[a[7:4]] && mt[a[7:4]] == a[31:8]) ? 0 : 1);
      e.issue_cyc    = cyc;
      e.refills_base = refills_done;
      sb.push_back(e);
   endtask

   task automatic wait_done(input logic [31:0] a);
      int n = 0;
      while (sb.size() > 0 && n < 400) begin
         @(posedge clk);
         n++;
      end
      if (sb.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL fetch_timeout: pc %h got no hit, required hit within %0d cycles", a, n);
         sb.delete();
      end
      mv[a[7:4]] = 1'b1;
      mt[a[7:4]] = a[31:8];
   endtask

   task automatic fetch(input logic [31:0] a);
      issue(a, -1);
      wait_done(a);
   endtask

   // Flush while idle; the held pc's line is invalidated and then refilled on its own.
   task automatic idle_flush();
      int n = 0;
      @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      clear_model();
      @(posedge clk);
      #2;
      while (mem_req && n < 100) begin
         @(posedge clk);
         #2;
         n++;
      end
      mv[pc[7:4]] = 1'b1;
      mt[pc[7:4]] = pc[31:8];
   endtask

   initial begin
      logic [31:0] a;
      int n;
      clear_model();
      repeat (3) @(posedge clk);
      #1;
      check32("reset_hit", 32'(hit), 32'd0);
      check32("reset_mem_req", 32'(mem_req), 32'd0);
      check32("reset_mem_addr", mem_addr, 32'd0);
      #2;
      rst_n = 1'b1;

      fetch(32'h40);
      fetch(32'h48);
      fetch(32'h440);
      fetch(32'h40);

      mem_delay = 3;
      fetch(32'h140);
      mem_delay = 1;

      // Flush arrives while the second word is being requested: two refills needed.
      issue(32'h80, 2);
      n = 0;
      do begin
         @(posedge clk);
         #2;
         n++;
      end while (words != 1 && n < 50);
      flush = 1'b1;
      @(posedge clk);
      #2;
      flush = 1'b0;
      clear_model();
      wait_done(32'h80);
      fetch(32'h40);
      fetch(32'h48);

      // Reset in the middle of a refill.
      mem_delay = 0;
      @(posedge clk);
      #1;
      exp_base = 32'h2C0;
      pc       = 32'h2C0;
      n = 0;
      do begin
         @(posedge clk);
         #2;
         n++;
      end while (words != 2 && n < 50);
      #1;
      rst_n = 1'b0;
      #1;
      check32("rst_mem_req", 32'(mem_req), 32'd0);
      check32("rst_mem_addr", mem_addr, 32'd0);
      check32("rst_hit", 32'(hit), 32'd0);
      pc       = 32'h40;
      exp_base = 32'h40;
      clear_model();
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      fetch(32'h40);
      fetch(32'h4C);

      rand_delay = 1'b1;
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 19) == 0) begin
            idle_flush();
         end else begin
            a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 4)
                | 32'($urandom_range(0, 15));
            fetch(a);
         end
      end

      repeat (5) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
      $fatal(1);
   end

endmodule
